serial_unpack: RTL and testbench

Bit-serial receive end for the arithmetic datapath: accepts an LSB-first serial word stream with a word-start strobe and deserializes it into parallel words. Completed words are queued in a small FIFO and delivered through a valid/ready handshake. It sits downstream of the serial adder stages and replaces the fixed-timing serial-to-parallel tap with a framed, back-pressured interface that detects errors.

---
 rtl/serial_unpack.sv | 152 +++++++++++++++
 tb/tb_serial_unpack.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_unpack.sv
// Bit-serial LSB-first word receiver with framing, optional parity and a small output FIFO.
// Optional parity bit per word is enabled by defining SERIAL_UNPACK_PARITY_EN.
module serial_unpack #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sin,
    input  logic                         sfirst,
    input  logic                         err_clr,
    output logic [W-1:0]                 q_data,
    output logic                         q_valid,
    input  logic                         q_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic                         frame_err,
    output logic                         par_err
);

`ifdef SERIAL_UNPACK_PARITY_EN
    localparam int unsigned F = W + 1;
`else
    localparam int unsigned F = W;
`endif
    localparam int unsigned CW = $clog2(F);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [F-1:0]    sreg;
    logic [W-1:0]    mem [DEPTH];
    logic [PW-1:0]   rptr;
    logic [PW-1:0]   wptr;

    logic [F-1:0]    sreg_n;
    logic [W-1:0]    word_c;
    logic            complete_c;
    logic            parity_ok_c;
    logic            pop_c;
    logic            push_c;
    logic            drop_c;
    logic            frame_set_c;
    logic [LW-1:0]   level_n;
    logic [PW-1:0]   rptr_nx;
    logic [PW-1:0]   wptr_nx;

`ifdef SERIAL_UNPACK_PARITY_EN
    assign parity_ok_c = ~(^sreg_n);
`else
    assign parity_ok_c = 1'b1;
`endif

    // Word assembly, completion detection and FIFO push/pop decisions.
    always_comb begin
        sreg_n       = sreg;
        sreg_n[cnt]  = sin;
        word_c       = sreg_n[W-1:0];
        complete_c   = (state == SHIFT) && !sfirst && (cnt == CW'(F - 1));
        frame_set_c  = (state == SHIFT) && sfirst;
        pop_c        = q_valid && q_ready;
        push_c       = complete_c && parity_ok_c && ((level != LW'(DEPTH)) || pop_c);
        drop_c       = complete_c && parity_ok_c && (level == LW'(DEPTH)) && !pop_c;
        level_n      = level + LW'(push_c) - LW'(pop_c);
        rptr_nx      = (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
        wptr_nx      = (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sreg      <= '0;
            rptr      <= '0;
            wptr      <= '0;
            level     <= '0;
            q_valid   <= 1'b0;
            q_data    <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sfirst) begin
                        sreg  <= F'(sin);
                        cnt   <= CW'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sfirst) begin
                        sreg <= F'(sin);
                        cnt  <= CW'(1);
                    end else if (complete_c) begin
                        sreg  <= sreg_n;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        sreg <= sreg_n;
                        cnt  <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // Head register tracks the word that will sit at the read pointer after this edge.
            if (pop_c) begin
                rptr <= rptr_nx;
                if (level > LW'(1)) begin
                    q_data <= mem[rptr_nx];
                end else if (push_c) begin
                    q_data <= word_c;
                end
            end else if (push_c && (level == '0)) begin
                q_data <= word_c;
            end
            if (push_c) begin
                wptr <= wptr_nx;
            end
            level   <= level_n;
            q_valid <= (level_n != '0);

            overflow  <= (overflow && !err_clr) || drop_c;
            frame_err <= (frame_err && !err_clr) || frame_set_c;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wptr] <= word_c;
        end
    end

`ifdef SERIAL_UNPACK_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err <= 1'b0;
        end else begin
            par_err <= (par_err && !err_clr) || (complete_c && !parity_ok_c);
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_unpack.sv
// Self-checking bench for serial_unpack: directed vector table, corner sequences and a queue-based random model.
module tb_serial_unpack;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned LW    = $clog2(DEPTH + 1);
`ifdef SERIAL_UNPACK_PARITY_EN
    localparam int unsigned F     = W + 1;
    localparam bit          PAR   = 1'b1;
`else
    localparam int unsigned F     = W;
    localparam bit          PAR   = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sin = 1'b0;
    logic          sfirst = 1'b0;
    logic          err_clr = 1'b0;
    logic [W-1:0]  q_data;
    logic          q_valid;
    logic          q_ready = 1'b0;
    logic [LW-1:0] level;
    logic          overflow;
    logic          frame_err;
    logic          par_err;

    serial_unpack #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sfirst    (sfirst),
        .err_clr   (err_clr),
        .q_data    (q_data),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .level     (level),
        .overflow  (overflow),
        .frame_err (frame_err),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a queue of delivered words and a list of bits of the word in flight.
    logic [W-1:0] mq [$];
    logic [W:0]   acc;
    int           nb;
    bit           collecting;
    bit           m_ovf, m_frm, m_par;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        acc = '0;
        nb = 0;
        collecting = 0;
        m_ovf = 0;
        m_frm = 0;
        m_par = 0;
    endtask

    task automatic model_edge(input logic b, input logic first, input logic rdy, input logic clr);
        bit pop, complete, set_o, set_f, set_p, full, par_ok;
        pop = (mq.size() > 0) && rdy;
        full = (mq.size() == DEPTH);
        complete = 0; set_o = 0; set_f = 0; set_p = 0;
        if (first) begin
            set_f = collecting;
            acc = '0;
            acc[0] = b;
            nb = 1;
            collecting = 1;
        end else if (collecting) begin
            acc[nb] = b;
            nb++;
            if (nb == F) begin
                complete = 1;
                collecting = 0;
            end
        end
        par_ok = !PAR || ((^acc[W-1:0]) == acc[W]);
        if (pop) void'(mq.pop_front());
        if (complete) begin
            if (!par_ok) set_p = 1;
            else if (!full || pop) mq.push_back(acc[W-1:0]);
            else set_o = 1;
        end
        m_ovf = (m_ovf && !clr) || set_o;
        m_frm = (m_frm && !clr) || set_f;
        m_par = (m_par && !clr) || set_p;
    endtask

    task automatic model_check();
        chk("m_valid", 32'(q_valid), 32'(mq.size() != 0));
        chk("m_level", 32'(level), 32'(mq.size()));
        if (mq.size() != 0) chk("m_data", 32'(q_data), 32'(mq[0]));
        chk("m_overflow", 32'(overflow), 32'(m_ovf));
        chk("m_frame_err", 32'(frame_err), 32'(m_frm));
        chk("m_par_err", 32'(par_err), 32'(m_par));
    endtask

    // One clock: drive, sample on the edge, update model, check 1 time unit later.
    task automatic step(input logic b, input logic first, input logic rdy, input logic clr);
        sin = b; sfirst = first; q_ready = rdy; err_clr = clr;
        @(posedge clk);
        model_edge(b, first, rdy, clr);
        #1;
        model_check();
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit flip, input logic rdy, input logic rdy_last);
        logic pb;
        pb = (^w) ^ flip;
        for (int i = 0; i < int'(F); i++) begin
            step((i < int'(W)) ? w[i] : pb, (i == 0), (i == int'(F) - 1) ? rdy_last : rdy, 1'b0);
        end
    endtask

    task automatic do_reset();
        sfirst = 0; sin = 0; err_clr = 0; q_ready = 0;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", 32'(q_valid), 32'h0);
        chk("rst_data", 32'(q_data), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_flags", {29'h0, overflow, frame_err, par_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic         b;
        logic         first;
        logic         rdy;
        logic         exp_valid;
        logic [W-1:0] exp_data;
        logic [LW-1:0] exp_level;
    } vec_t;

    vec_t tbl [F+1];

    initial begin
        logic [W-1:0] a5;
        logic [W-1:0] w;
        int pos;
        bit f;
        a5 = 8'hA5;
        for (int i = 0; i <= int'(F); i++) begin
            tbl[i].b         = (i < int'(W)) ? a5[i] : 1'b0;
            tbl[i].first     = (i == 0);
            tbl[i].rdy       = 1'b1;
            tbl[i].exp_valid = (i == int'(F) - 1);
            tbl[i].exp_data  = 8'hA5;
            tbl[i].exp_level = (i == int'(F) - 1) ? LW'(1) : LW'(0);
        end

        do_reset();

        // 0xA5 through the vector table: valid for exactly one cycle
        for (int i = 0; i <= int'(F); i++) begin
            step(tbl[i].b, tbl[i].first, tbl[i].rdy, 1'b0);
            chk("tbl_valid", 32'(q_valid), 32'(tbl[i].exp_valid));
            chk("tbl_level", 32'(level), 32'(tbl[i].exp_level));
            if (tbl[i].exp_valid) chk("tbl_data", 32'(q_data), 32'(tbl[i].exp_data));
            chk("tbl_flags", {29'h0, overflow, frame_err, par_err}, 32'h0);
        end

        // Overflow: three back-to-back words into a two-deep FIFO
        send_word(8'h01, 0, 0, 0);
        send_word(8'h80, 0, 0, 0);
        send_word(8'hFF, 0, 0, 0);
        chk("ovf_level", 32'(level), 32'd2);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_head", 32'(q_data), 32'h01);
        step(0, 0, 1, 0);
        chk("drain1_data", 32'(q_data), 32'h80);
        chk("drain1_valid", 32'(q_valid), 32'd1);
        step(0, 0, 1, 0);
        chk("drain2_valid", 32'(q_valid), 32'd0);
        step(0, 0, 0, 1);
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Framing error: restart after 3 bits
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        send_word(8'h3C, 0, 1, 1);
        chk("frm_flag", 32'(frame_err), 32'd1);
        chk("frm_data", 32'(q_data), 32'h3C);
        chk("frm_level", 32'(level), 32'd1);
        step(0, 0, 1, 1);
        chk("frm_cleared", 32'(frame_err), 32'd0);
        chk("frm_drained", 32'(q_valid), 32'd0);

        // Full FIFO with a simultaneous pop at word completion
        send_word(8'h11, 0, 0, 0);
        send_word(8'h22, 0, 0, 0);
        send_word(8'h33, 0, 0, 1);
        chk("pp_level", 32'(level), 32'd2);
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_head", 32'(q_data), 32'h22);
        step(0, 0, 1, 0);
        chk("pp_next", 32'(q_data), 32'h33);
        step(0, 0, 1, 0);
        chk("pp_empty", 32'(q_valid), 32'd0);

        // Reset mid-word with one word queued
        send_word(8'h44, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        do_reset();
        send_word(8'h5A, 0, 0, 0);
        chk("rst_next_data", 32'(q_data), 32'h5A);
        chk("rst_next_level", 32'(level), 32'd1);
        step(0, 0, 1, 0);

`ifdef SERIAL_UNPACK_PARITY_EN
        // Parity: bad parity is dropped, good parity delivered
        send_word(8'h03, 1, 1, 1);
        chk("par_flag", 32'(par_err), 32'd1);
        chk("par_none", 32'(q_valid), 32'd0);
        send_word(8'h03, 0, 1, 1);
        chk("par_data", 32'(q_data), 32'h03);
        chk("par_valid", 32'(q_valid), 32'd1);
        step(0, 0, 1, 1);
`endif

        // Randomized traffic against the model
        pos = 0;
        for (int c = 0; c < 3000; c++) begin
            if (pos == 0) begin
                f = ($urandom_range(0, 3) != 0);
                if (f) pos = 1;
            end else begin
                f = ($urandom_range(0, 49) == 0);
                pos = f ? 1 : ((pos + 1) % int'(F));
            end
            w = W'($urandom);
            step(w[0], f, ($urandom_range(0, 2) != 0), ($urandom_range(0, 29) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
